// File: rtl/sram_wl_access_sequencer.sv
// Timed SRAM access sequencer: precharge -> one-hot wordline -> recovery per accepted request,
// with write-driver / sense-amp control and break-before-make between precharge and wordlines.
module sram_wl_access_sequencer #(
  parameter int ROW_BITS = 6,
  parameter int NUM_ROWS = 64,
  parameter int DW       = 8,
  parameter int PRE_CYC  = 2,
  parameter int WL_CYC   = 3,
  parameter int REC_CYC  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ROW_BITS-1:0] req_row,
  input  logic [DW-1:0]       req_wdata,
  output logic [NUM_ROWS-1:0] wl,
  output logic                precharge_en,
  output logic                bl_drive_en,
  output logic [DW-1:0]       bl_wdata,
  output logic                sense_en,
  output logic                done,
  output logic                err
);

  localparam int MAXC = (PRE_CYC > WL_CYC) ? ((PRE_CYC > REC_CYC) ? PRE_CYC : REC_CYC)
                                           : ((WL_CYC > REC_CYC) ? WL_CYC : REC_CYC);
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_CYC - 1);
  localparam logic [CW-1:0] WL_LAST  = CW'(WL_CYC - 1);
  localparam logic [CW-1:0] REC_LAST = CW'(REC_CYC - 1);

  typedef enum logic [1:0] {IDLE, PRECH, WL_ON, RECOVER} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                we_q;
  logic [ROW_BITS-1:0] row_q;
  logic [DW-1:0]       wdata_q;
  logic                accept;
  logic                row_ok;
  logic [NUM_ROWS-1:0] wl_dec;
  logic                wl_phase_nxt;
  logic                last_wl_nxt;
  logic                last_rec_nxt;

  // Gated by rst_n so that every output reads 0 while reset is held.
  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = PRECH;
          cnt_nxt   = '0;
        end
      end
      PRECH: begin
        if (cnt == PRE_LAST) begin
          state_nxt = WL_ON;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WL_ON: begin
        if (cnt == WL_LAST) begin
          state_nxt = RECOVER;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RECOVER: begin
        if (cnt == REC_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state view so each line changes on the phase edge itself.
  always_comb begin
    row_ok       = (32'(row_q) < NUM_ROWS);
    wl_dec       = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      wl_dec[i] = row_ok && (row_q == ROW_BITS'(i));
    end
    wl_phase_nxt = (state_nxt == WL_ON);
    last_wl_nxt  = wl_phase_nxt && (cnt_nxt == WL_LAST);
    last_rec_nxt = (state_nxt == RECOVER) && (cnt_nxt == REC_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wl           <= '0;
      precharge_en <= 1'b0;
      bl_drive_en  <= 1'b0;
      bl_wdata     <= '0;
      sense_en     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      wl           <= wl_phase_nxt ? wl_dec : '0;
      precharge_en <= (state_nxt == PRECH);
      bl_drive_en  <= wl_phase_nxt && we_q;
      bl_wdata     <= (wl_phase_nxt && we_q) ? wdata_q : '0;
      sense_en     <= last_wl_nxt && !we_q;
      done         <= last_rec_nxt;
      err          <= last_rec_nxt && !row_ok;
    end
  end

  // Request fields are pure data; they are only consumed after an accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      row_q   <= req_row;
      wdata_q <= req_wdata;
    end
  end

endmodule

// File: tb/tb_sram_wl_access_sequencer.sv
// Bench for sram_wl_access_sequencer: a 64-row and a 48-row instance share stimulus and are
// compared every cycle against a cycle-index model of the access timeline.
module tb_sram_wl_access_sequencer;

  localparam int PRE   = 2;
  localparam int WLC   = 3;
  localparam int REC   = 1;
  localparam int TOTAL = PRE + WLC + REC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [5:0]  req_row;
  logic [7:0]  req_wdata;

  logic        req_ready0, precharge0, drive0, sense0, done0, err0;
  logic [63:0] wl0;
  logic [7:0]  wdata0;
  logic        req_ready1, precharge1, drive1, sense1, done1, err1;
  logic [47:0] wl1;
  logic [7:0]  wdata1;

  always #5 clk = ~clk;

  sram_wl_access_sequencer #(
    .ROW_BITS(6), .NUM_ROWS(64), .DW(8), .PRE_CYC(PRE), .WL_CYC(WLC), .REC_CYC(REC)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
    .req_we(req_we), .req_row(req_row), .req_wdata(req_wdata), .wl(wl0),
    .precharge_en(precharge0), .bl_drive_en(drive0), .bl_wdata(wdata0),
    .sense_en(sense0), .done(done0), .err(err0)
  );

  sram_wl_access_sequencer #(
    .ROW_BITS(6), .NUM_ROWS(48), .DW(8), .PRE_CYC(PRE), .WL_CYC(WLC), .REC_CYC(REC)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .req_row(req_row), .req_wdata(req_wdata), .wl(wl1),
    .precharge_en(precharge1), .bl_drive_en(drive1), .bl_wdata(wdata1),
    .sense_en(sense1), .done(done1), .err(err1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position t (1..TOTAL) of the current access since its accept edge.
  bit         busy = 1'b0;
  int         t = 0;
  bit         m_we;
  int         m_row;
  logic [7:0] m_wd;
  int         cyc = 0;
  int         acc_q[$];

  function automatic bit in_wl();
    return busy && (t > PRE) && (t <= PRE + WLC);
  endfunction

  function automatic logic [63:0] exp_wl(input int nr);
    if (in_wl() && (m_row < nr)) return 64'(1) << m_row;
    return 64'd0;
  endfunction

  task automatic model_edge(input bit v, input bit we, input int row, input logic [7:0] wd);
    if (!rst_n) begin
      busy = 1'b0;
    end else if (busy) begin
      if (t == TOTAL) busy = 1'b0;
      else t++;
    end else if (v) begin
      busy = 1'b1;
      t    = 1;
      m_we = we;
      m_row = row;
      m_wd = wd;
    end
  endtask

  task automatic check_all();
    bit dn;
    dn = busy && (t == TOTAL);
    chk("ready",      64'(req_ready0), 64'(rst_n && !busy));
    chk("precharge",  64'(precharge0), 64'(busy && t <= PRE));
    chk("wl64",       wl0,             exp_wl(64));
    chk("drive",      64'(drive0),     64'(in_wl() && m_we));
    chk("bl_wdata",   64'(wdata0),     (in_wl() && m_we) ? 64'(m_wd) : 64'd0);
    chk("sense",      64'(sense0),     64'(in_wl() && !m_we && t == PRE + WLC));
    chk("done",       64'(done0),      64'(dn));
    chk("err64",      64'(err0),       64'(dn && m_row >= 64));
    chk("ready48",    64'(req_ready1), 64'(rst_n && !busy));
    chk("wl48",       64'(wl1),        exp_wl(48));
    chk("done48",     64'(done1),      64'(dn));
    chk("err48",      64'(err1),       64'(dn && m_row >= 48));
  endtask

  task automatic step(input bit v, input bit we, input logic [5:0] row, input logic [7:0] wd);
    bit acc;
    req_valid = v;
    req_we    = we;
    req_row   = row;
    req_wdata = wd;
    acc = v && req_ready0;
    @(posedge clk);
    model_edge(v, we, int'(row), wd);
    cyc++;
    if (acc) acc_q.push_back(cyc);
    #1;
    check_all();
  endtask

  // Structural invariants on both instances, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_onehot64", 64'($onehot0(wl0)), 64'd1);
      chk("inv_bbm64",    64'((wl0 != 0) && precharge0), 64'd0);
      chk("inv_drv_sns",  64'(drive0 && sense0), 64'd0);
      chk("inv_onehot48", 64'($onehot0(wl1)), 64'd1);
      chk("inv_bbm48",    64'((wl1 != 0) && precharge1), 64'd0);
    end
  end

  typedef struct {
    bit          we;
    logic [5:0]  row;
    logic [7:0]  wd;
    logic [63:0] exp_wl64;
    logic [63:0] exp_wl48;
    bit          exp_err48;
    logic [7:0]  exp_data;
    int          exp_drive_cyc;
    int          exp_sense_cyc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [63:0] wl_or0, wl_or1;
    logic [7:0]  data_or;
    int          drv_n, sns_n, done_at;
    bit          err_seen;

    vecs[0] = '{1'b1, 6'd5,  8'hA5, 64'h20,                  64'h20,                  1'b0, 8'hA5, 3, 0};
    vecs[1] = '{1'b0, 6'd63, 8'h77, 64'h8000_0000_0000_0000, 64'h0,                   1'b1, 8'h00, 0, 1};
    vecs[2] = '{1'b1, 6'd50, 8'h3C, 64'h0004_0000_0000_0000, 64'h0,                   1'b1, 8'h3C, 3, 0};
    vecs[3] = '{1'b0, 6'd47, 8'hFF, 64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000, 1'b0, 8'h00, 0, 1};
    vecs[4] = '{1'b1, 6'd0,  8'hFF, 64'h1,                   64'h1,                   1'b0, 8'hFF, 3, 0};

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_row = '0;
    req_wdata = '0;
    #23;
    chk("rst_ready",     64'(req_ready0), 64'd0);
    chk("rst_wl",        wl0,             64'd0);
    chk("rst_precharge", 64'(precharge0), 64'd0);
    chk("rst_done",      64'(done0),      64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 64'(req_ready0), 64'd1);
    chk("rel_wl",    wl0,             64'd0);
    step(1'b0, 1'b0, 6'd0, 8'h0);

    // Directed table: one access per record, with per-access summaries.
    for (int k = 0; k < 5; k++) begin
      wl_or0 = '0; wl_or1 = '0; data_or = '0;
      drv_n = 0; sns_n = 0; done_at = 0; err_seen = 1'b0;
      for (int i = 1; i <= TOTAL + 1; i++) begin
        step(i == 1, vecs[k].we, vecs[k].row, vecs[k].wd);
        wl_or0  |= wl0;
        wl_or1  |= 64'(wl1);
        data_or |= wdata0;
        if (drive0) drv_n++;
        if (sense0) sns_n++;
        if (done0 && done_at == 0) done_at = i;
        if (err1) err_seen = 1'b1;
      end
      chk($sformatf("vec%0d_wl64", k),  wl_or0,           vecs[k].exp_wl64);
      chk($sformatf("vec%0d_wl48", k),  wl_or1,           vecs[k].exp_wl48);
      chk($sformatf("vec%0d_err48", k), 64'(err_seen),    64'(vecs[k].exp_err48));
      chk($sformatf("vec%0d_data", k),  64'(data_or),     64'(vecs[k].exp_data));
      chk($sformatf("vec%0d_drv", k),   64'(drv_n),       64'(vecs[k].exp_drive_cyc));
      chk($sformatf("vec%0d_sns", k),   64'(sns_n),       64'(vecs[k].exp_sense_cyc));
      chk($sformatf("vec%0d_done", k),  64'(done_at),     64'(TOTAL));
    end

    // Asynchronous reset in the middle of the wordline phase.
    step(1'b1, 1'b1, 6'd9, 8'h5A);
    step(1'b0, 1'b1, 6'd9, 8'h5A);
    step(1'b0, 1'b1, 6'd9, 8'h5A);
    chk("pre_rst_wl", wl0, 64'h200);
    #2;
    rst_n = 1'b0;
    #1;
    busy = 1'b0;
    chk("async_wl",    wl0,             64'd0);
    chk("async_drive", 64'(drive0),     64'd0);
    chk("async_data",  64'(wdata0),     64'd0);
    chk("async_ready", 64'(req_ready0), 64'd0);
    step(1'b1, 1'b0, 6'd9, 8'h00);
    step(1'b1, 1'b0, 6'd9, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready0), 64'd1);
    acc_q.delete();
    done_at = 0;
    for (int i = 1; i <= TOTAL + 1; i++) begin
      step(i == 1, 1'b0, 6'd12, 8'h00);
      if (done0 && done_at == 0) done_at = i;
    end
    chk("post_rst_accepts", 64'(acc_q.size()), 64'd1);
    chk("post_rst_done",    64'(done_at),      64'(TOTAL));

    // Request held continuously: accepts must be one full access plus one idle cycle apart.
    acc_q.delete();
    for (int i = 0; i < 5 * (TOTAL + 1); i++) step(1'b1, 1'b0, 6'd3, 8'h00);
    chk("held_accepts", 64'(acc_q.size()), 64'd5);
    for (int i = 1; i < acc_q.size(); i++)
      chk($sformatf("held_gap%0d", i), 64'(acc_q[i] - acc_q[i-1]), 64'(TOTAL + 1));
    for (int i = 0; i <= TOTAL; i++) step(1'b0, 1'b0, 6'd0, 8'h00);

    // Random traffic, including valid toggling while busy.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i <= TOTAL; i++) step(1'b0, 1'b0, 6'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
